core_bus_arb: RTL
=================

// Module: core_bus_arb
// PURPOSE
//  Two-master to one-slave arbiter for the core's pipelined Wishbone port.
//  Shares the single external bus between instruction fetch (m0) and the
//  memory access unit (m1). Grants whole bus cycles (cyc-to-cyc), tracks
//  outstanding pipelined requests, routes ack/err/dat back to the owner.
// PARAMETERS
//  AW       32  address width
//  DW       32  data width; sel width is DW/8
//  MAX_OUT  4   max outstanding (stb accepted, not yet acked) requests, >=1
//  RR       1   1 = round-robin on contention; 0 = fixed priority, m1 wins
// PORTS
//  clk          in   1     core clock
//  rst          in   1     asynchronous, active-low reset
//  mN_cyc       in   1     master N bus-cycle request (N = 0 fetch, 1 mau)
//  mN_stb       in   1     master N strobe
//  mN_we        in   1     master N write enable
//  mN_adr       in   AW    master N address
//  mN_sel       in   DW/8  master N byte select
//  mN_dat_mo    in   DW    master N write data
//  mN_stall     out  1     stall to master N
//  mN_ack       out  1     ack to master N
//  mN_err       out  1     err to master N
//  mN_dat_so    out  DW    read data to master N (s_dat_so, unqualified)
//  s_cyc/s_stb/s_we/s_adr/s_sel/s_dat_mo  out  1/1/1/AW/DW/8/DW  to slave
//  s_stall/s_ack/s_err/s_dat_so           in   1/1/1/DW          from slave
//  grant        out  2     one-hot owner {m1,m0}; 2'b00 = idle
//  proto_err    out  1     sticky: ack/err received with nothing outstanding
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE, grant=00, count=0, last=m0,
//    proto_err=0. All s_* controls 0, s_adr/s_sel/s_dat_mo 0; mN_stall=1,
//    mN_ack=0, mN_err=0.
//  - FSM IDLE / OWN0 / OWN1, registered. grant mirrors state.
//  - IDLE: one mN_cyc high -> OWNN next edge. Both high: RR=1 -> the master
//    other than `last`; RR=0 -> m1. Grant latency: 1 cycle after cyc seen.
//  - OWNN: s_cyc=mN_cyc; s_we/adr/sel/dat_mo = master N's, combinational.
//    s_stb = mN_stb & (count<MAX_OUT). mN_stall = s_stall | (count==MAX_OUT).
//    mN_ack=s_ack, mN_err=s_err. Non-owner: stall=1, ack=0, err=0.
//  - Accept = s_stb & !s_stall. Complete = s_ack | s_err.
//    count: +1 on accept only, -1 on complete only, unchanged on both.
//    Complete with count==0: count stays 0, proto_err<=1 (cleared by reset
//    only); the stray ack/err is still forwarded to the owner.
//  - Release when owner's cyc==0 AND count==0 (count after this edge's
//    update is not used; the registered value is). On release: last<=N; if
//    other master's cyc high -> OWN(other) directly (no IDLE bubble), else
//    IDLE. Owner dropping cyc with count>0: s_cyc held 1 (forced) until
//    count reaches 0, s_stb forced 0, acks still routed to old owner.
//  - s_err does not abort tracking: counted like ack.
//  - No master may be granted while the other owns; no preemption.
//  - Reset mid-cycle: bus drops immediately; in-flight responses after
//    reset release are counted as stray (proto_err) only if a new owner
//    has count==0 and they arrive -- this is accepted behaviour.
// TESTING
//  1 Reset: rst=0 for 3 cycles with m0_cyc=1 -> grant=00, s_cyc=0,
//    m0_stall=1; rst=1 -> grant=01 after 1 edge.
//  2 Contention RR=1: m0_cyc,m1_cyc both rise at t0 from reset -> grant=10
//    (last=m0); m1 does 2 reads, acks, drops cyc -> grant=01 next edge,
//    no IDLE cycle.
//  3 Backpressure MAX_OUT=4: m1 issues 6 back-to-back stb, slave never
//    acks -> exactly 4 accepts, m1_stall=1 from 5th; one ack -> 5th
//    accepted next cycle.
//  4 Late acks: m0 issues 3 reads, drops cyc after 3rd accept -> s_cyc
//    stays 1, s_stb=0, grant=01 until 3rd ack, then release; m1 (waiting)
//    granted same edge.
//  5 Stray ack: IDLE->OWN0, count=0, slave pulses s_ack -> proto_err=1,
//    m0_ack=1, count=0; proto_err holds until reset.
//  6 Err: m1 write, slave s_err -> m1_err=1, m0_err=0, count 1->0, release.

Source files
------------

// File: rtl/core_bus_arb.sv
// core_bus_arb: two-master to one-slave pipelined Wishbone arbiter with outstanding-request tracking
module core_bus_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MAX_OUT = 4,
  parameter int RR      = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_cyc,
  input  logic            m0_stb,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW/8-1:0] m0_sel,
  input  logic [DW-1:0]   m0_dat_mo,
  output logic            m0_stall,
  output logic            m0_ack,
  output logic            m0_err,
  output logic [DW-1:0]   m0_dat_so,
  input  logic            m1_cyc,
  input  logic            m1_stb,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW/8-1:0] m1_sel,
  input  logic [DW-1:0]   m1_dat_mo,
  output logic            m1_stall,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [DW-1:0]   m1_dat_so,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_mo,
  input  logic            s_stall,
  input  logic            s_ack,
  input  logic            s_err,
  input  logic [DW-1:0]   s_dat_so,
  output logic [1:0]      grant,
  output logic            proto_err
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUT);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic last_q, last_d, perr_q, perr_d;
  logic own0, own1, o_cyc, o_stb, full, busy, acc, cmp, pick1, rel0, rel1;
  always_comb begin
    own0 = state_q == OWN0;
    own1 = state_q == OWN1;
    o_cyc = own1 ? m1_cyc : own0 & m0_cyc;
    o_stb = own1 ? m1_stb : own0 & m0_stb;
    full = count_q == MAXC;
    busy = count_q != '0;
    // bus cycle is held open after the owner drops cyc until every response is back
    s_cyc = o_cyc | ((own0 | own1) & busy);
    s_stb = o_cyc & o_stb & !full;
    s_we = own1 ? m1_we : own0 & m0_we;
    s_adr = own1 ? m1_adr : own0 ? m0_adr : '0;
    s_sel = own1 ? m1_sel : own0 ? m0_sel : '0;
    s_dat_mo = own1 ? m1_dat_mo : own0 ? m0_dat_mo : '0;
    m0_stall = !own0 | s_stall | full;
    m1_stall = !own1 | s_stall | full;
    m0_ack = own0 & s_ack;
    m1_ack = own1 & s_ack;
    m0_err = own0 & s_err;
    m1_err = own1 & s_err;
    m0_dat_so = s_dat_so;
    m1_dat_so = s_dat_so;
    grant = {own1, own0};
    proto_err = perr_q;
    acc = s_stb & !s_stall;
    cmp = s_ack | s_err;
    count_d = (acc & !cmp) ? count_q + 1'b1 : (cmp & !acc & busy) ? count_q - 1'b1 : count_q;
    perr_d = perr_q | (cmp & !busy);
    pick1 = m1_cyc & (!m0_cyc | RR == 0 | !last_q);
    rel0 = own0 & !m0_cyc & !busy;
    rel1 = own1 & !m1_cyc & !busy;
    state_d = state_q;
    last_d = last_q;
    if (state_q == IDLE) state_d = pick1 ? OWN1 : m0_cyc ? OWN0 : IDLE;
    else if (rel0) begin
      state_d = m1_cyc ? OWN1 : IDLE;
      last_d = 1'b0;
    end else if (rel1) begin
      state_d = m0_cyc ? OWN0 : IDLE;
      last_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q <= last_d;
      perr_q <= perr_d;
    end
  end
endmodule
